// File: rtl/qos_pkg.sv
// Shared definitions for the QoS interconnect scheduler.
//   sched_state_e : scheduler FSM encoding (IDLE=0, SERVE_VC0=1, SERVE_VC1=2)
//   TAG_VC0/1     : source tag carried with a popped word through the steer pipe
//   DEFAULT_BW    : word width of the interconnect FIFOs
//   CNT_W         : width of the burst counter
package qos_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_VC0 = 2'd1,
    SERVE_VC1 = 2'd2
  } sched_state_e;

  localparam logic TAG_VC0    = 1'b0;
  localparam logic TAG_VC1    = 1'b1;
  localparam int   DEFAULT_BW = 6;
  localparam int   CNT_W      = 3;

endpackage

// File: rtl/vc_steer.sv
// Two-stage steering pipeline between the VC FIFO read ports and the D FIFOs.
// Stage 1 remembers that a pop happened and which VC it came from; the VC read
// data becomes valid in that cycle and is captured into the destination port
// chosen by word[DEST_BIT]. Stage 2 is the registered D push (wr + data).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   pop_vc0, pop_vc1    : pop strobes issued to the VC FIFOs this cycle
//   vc0_data, vc1_data  : VC FIFO read data (valid the cycle after the pop)
//   d0_wr/d0_data       : D0 push strobe and data (data holds when wr is low)
//   d1_wr/d1_data       : D1 push strobe and data
//   busy                : a popped word is still in stage 1 or stage 2
module vc_steer
  import qos_pkg::*;
#(
  parameter int BW       = DEFAULT_BW,
  parameter int DEST_BIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pop_vc0,
  input  logic          pop_vc1,
  input  logic [BW-1:0] vc0_data,
  input  logic [BW-1:0] vc1_data,
  output logic          d0_wr,
  output logic [BW-1:0] d0_data,
  output logic          d1_wr,
  output logic [BW-1:0] d1_data,
  output logic          busy
);

  logic          s1_valid_q, s1_valid_d;
  logic          s1_tag_q, s1_tag_d;
  logic [BW-1:0] word;
  logic          dest;
  logic [1:0]    d_wr_o;
  logic [BW-1:0] d_data_o [2];

  always_comb begin
    s1_valid_d = pop_vc0 | pop_vc1;
    s1_tag_d   = pop_vc1 ? TAG_VC1 : TAG_VC0;
    // The FIFO read data is only valid in the cycle after the pop, so the
    // word is selected by the tag registered alongside the valid bit.
    word       = (s1_tag_q == TAG_VC1) ? vc1_data : vc0_data;
    dest       = word[DEST_BIT];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= TAG_VC0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic          wr_q, wr_d;
      logic [BW-1:0] data_q, data_d;

      always_comb begin
        wr_d   = s1_valid_q & (dest == 1'(gi));
        data_d = wr_d ? word : data_q;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_q   <= 1'b0;
          data_q <= '0;
        end else begin
          wr_q   <= wr_d;
          data_q <= data_d;
        end
      end

      assign d_wr_o[gi]   = wr_q;
      assign d_data_o[gi] = data_q;
    end
  endgenerate

  assign d0_wr   = d_wr_o[0];
  assign d0_data = d_data_o[0];
  assign d1_wr   = d_wr_o[1];
  assign d1_data = d_data_o[1];
  assign busy    = s1_valid_q | d_wr_o[0] | d_wr_o[1];

endmodule

// File: rtl/vc_scheduler.sv
// Weighted round-robin scheduler from two VC FIFOs to two destination FIFOs.
// VC0 may take up to WEIGHT_VC0 consecutive pops while VC1 waits, VC1 up to
// WEIGHT_VC1 while VC0 waits. Popped words are steered to D0/D1 by
// word[DEST_BIT] two cycles later. Any downstream almost-full stalls all pops.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   vc0_empty, vc0_rd, vc0_data   : VC0 FIFO flag, pop, read data
//   vc1_empty, vc1_rd, vc1_data   : VC1 FIFO flag, pop, read data
//   d0_almost_full, d0_wr, d0_data: D0 FIFO flag, push, push data
//   d1_almost_full, d1_wr, d1_data: D1 FIFO flag, push, push data
//   sched_idle                    : IDLE with no word in flight
module vc_scheduler
  import qos_pkg::*;
#(
  parameter int BW         = DEFAULT_BW,
  parameter int DEST_BIT   = 4,
  parameter int WEIGHT_VC0 = 3,
  parameter int WEIGHT_VC1 = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vc0_empty,
  output logic          vc0_rd,
  input  logic [BW-1:0] vc0_data,
  input  logic          vc1_empty,
  output logic          vc1_rd,
  input  logic [BW-1:0] vc1_data,
  input  logic          d0_almost_full,
  output logic          d0_wr,
  output logic [BW-1:0] d0_data,
  input  logic          d1_almost_full,
  output logic          d1_wr,
  output logic [BW-1:0] d1_data,
  output logic          sched_idle
);

  localparam logic [CNT_W-1:0] LAST_VC0 = CNT_W'(WEIGHT_VC0 - 1);
  localparam logic [CNT_W-1:0] LAST_VC1 = CNT_W'(WEIGHT_VC1 - 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;
  logic             steer_busy;

  // The destination is unknown until the word is read, so either D FIFO
  // being almost full blocks every pop.
  assign stall  = d0_almost_full | d1_almost_full;
  assign vc0_rd = (state_q == SERVE_VC0) & ~vc0_empty & ~stall;
  assign vc1_rd = (state_q == SERVE_VC1) & ~vc1_empty & ~stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      case (state_q)
        IDLE: begin
          if (!vc0_empty)      state_d = SERVE_VC0;
          else if (!vc1_empty) state_d = SERVE_VC1;
        end
        SERVE_VC0: begin
          if (vc0_empty && vc1_empty) begin
            state_d = IDLE;
          end else if (!vc1_empty && ((vc0_rd && cnt_q == LAST_VC0) || vc0_empty)) begin
            state_d = SERVE_VC1;
          end else if (vc0_rd && cnt_q != LAST_VC0) begin
            // With VC1 empty the burst is unlimited; the count parks at the
            // last slot so the switch fires on the first pop after VC1 fills.
            cnt_d = cnt_q + 1'b1;
          end
        end
        SERVE_VC1: begin
          if (vc0_empty && vc1_empty) begin
            state_d = IDLE;
          end else if (!vc0_empty && ((vc1_rd && cnt_q == LAST_VC1) || vc1_empty)) begin
            state_d = SERVE_VC0;
          end else if (vc1_rd && cnt_q != LAST_VC1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  vc_steer #(
    .BW       (BW),
    .DEST_BIT (DEST_BIT)
  ) u_steer (
    .clk      (clk),
    .reset    (reset),
    .pop_vc0  (vc0_rd),
    .pop_vc1  (vc1_rd),
    .vc0_data (vc0_data),
    .vc1_data (vc1_data),
    .d0_wr    (d0_wr),
    .d0_data  (d0_data),
    .d1_wr    (d1_wr),
    .d1_data  (d1_data),
    .busy     (steer_busy)
  );

  assign sched_idle = (state_q == IDLE) & ~steer_busy;

endmodule

// File: tb/tb_vc_scheduler.sv
// Bench for vc_scheduler. Instance 0 uses the default weights, instance 1
// overrides WEIGHT_VC0=1. Each instance reads from bench-side VC FIFO models.
// A per-cycle checker predicts every D push from the observed pops (word
// popped at cycle t appears on D[word[4]] at t+2, dropped by reset), checks
// pop legality, and logs the pop order for the directed tests below.
module tb_vc_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic d0_af, d1_af;

  logic       vc_empty_s [2][2];
  logic       rd_s       [2][2];
  logic [5:0] vc_data_s  [2][2];
  logic       d_wr_s     [2][2];
  logic [5:0] d_data_s   [2][2];
  logic       idle_s     [2];

  logic [5:0] mem [2][2][64];
  int wp [2][2] = '{'{0, 0}, '{0, 0}};
  int rp [2][2] = '{'{0, 0}, '{0, 0}};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      vc_scheduler #(
        .BW         (6),
        .DEST_BIT   (4),
        .WEIGHT_VC0 ((gi == 0) ? 3 : 1),
        .WEIGHT_VC1 (1)
      ) u_dut (
        .clk            (clk),
        .reset          (rst),
        .vc0_empty      (vc_empty_s[gi][0]),
        .vc0_rd         (rd_s[gi][0]),
        .vc0_data       (vc_data_s[gi][0]),
        .vc1_empty      (vc_empty_s[gi][1]),
        .vc1_rd         (rd_s[gi][1]),
        .vc1_data       (vc_data_s[gi][1]),
        .d0_almost_full (d0_af),
        .d0_wr          (d_wr_s[gi][0]),
        .d0_data        (d_data_s[gi][0]),
        .d1_almost_full (d1_af),
        .d1_wr          (d_wr_s[gi][1]),
        .d1_data        (d_data_s[gi][1]),
        .sched_idle     (idle_s[gi])
      );
    end
  endgenerate

  // VC FIFO models: empty from pointers, read data registered on a pop.
  always_comb begin
    for (int i = 0; i < 2; i++)
      for (int v = 0; v < 2; v++)
        vc_empty_s[i][v] = (wp[i][v] == rp[i][v]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      for (int v = 0; v < 2; v++)
        if (rd_s[i][v] === 1'b1) begin
          vc_data_s[i][v] <= mem[i][v][rp[i][v][5:0]];
          rp[i][v]        <= rp[i][v] + 1;
        end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int i, input int v, input logic [5:0] w);
    mem[i][v][wp[i][v][5:0]] = w;
    wp[i][v] = wp[i][v] + 1;
  endtask

  // Model state and logs.
  int         cyc = 0;
  logic       m1_v [2] = '{1'b0, 1'b0};
  logic       m2_v [2] = '{1'b0, 1'b0};
  logic [5:0] m1_w [2] = '{6'd0, 6'd0};
  logic [5:0] m2_w [2] = '{6'd0, 6'd0};
  logic [5:0] exp_last [2][2] = '{'{6'd0, 6'd0}, '{6'd0, 6'd0}};
  int         push_cnt [2][2];
  int         n_pop [2];
  int         seq [2][64];
  int         first_cyc [2];
  int         last_cyc [2];

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      logic pv;
      logic [5:0] pw;
      logic exp_wr;
      chk($sformatf("rd_both[%0d]", i), int'(rd_s[i][0] && rd_s[i][1]), 0);
      for (int v = 0; v < 2; v++) begin
        chk($sformatf("rd_when_empty[%0d] vc%0d", i, v), int'(rd_s[i][v] && vc_empty_s[i][v]), 0);
        chk($sformatf("rd_when_stall[%0d] vc%0d", i, v), int'(rd_s[i][v] && (d0_af || d1_af)), 0);
      end
      for (int p = 0; p < 2; p++) begin
        exp_wr = m2_v[i] && (int'(m2_w[i][4]) == p);
        if (exp_wr) exp_last[i][p] = m2_w[i];
        chk($sformatf("d%0d_wr[%0d] cyc %0d", p, i, cyc), int'(d_wr_s[i][p]), int'(exp_wr));
        chk($sformatf("d%0d_data[%0d] cyc %0d", p, i, cyc), int'(d_data_s[i][p]), int'(exp_last[i][p]));
        if (d_wr_s[i][p]) push_cnt[i][p]++;
      end
      m2_v[i] = m1_v[i];
      m2_w[i] = m1_w[i];
      pv = rd_s[i][0] || rd_s[i][1];
      pw = rd_s[i][1] ? mem[i][1][rp[i][1][5:0]] : mem[i][0][rp[i][0][5:0]];
      m1_v[i] = pv;
      m1_w[i] = pw;
      if (pv) begin
        seq[i][n_pop[i][5:0]] = rd_s[i][1] ? 1 : 0;
        if (n_pop[i] == 0) first_cyc[i] = cyc;
        last_cyc[i] = cyc;
        n_pop[i]++;
      end
      if (rst) begin
        // Everything in flight at a reset edge is dropped, outputs clear.
        m1_v[i] = 1'b0;
        m2_v[i] = 1'b0;
        exp_last[i][0] = 6'd0;
        exp_last[i][1] = 6'd0;
      end
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      n_pop[i] = 0;
      push_cnt[i][0] = 0;
      push_cnt[i][1] = 0;
    end
  endtask

  task automatic wait_idle(input int i);
    bit done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (idle_s[i] && vc_empty_s[i][0] && vc_empty_s[i][1]) begin
        done = 1'b1;
        break;
      end
    end
    chk($sformatf("idle_reached[%0d]", i), int'(done), 1);
    @(posedge clk);
    #2;
  endtask

  int ord_wrr [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int ord_alt [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    logic [5:0] rd_hist, wr_hist, idle_hist;
    int pops_in_stall, pushes_in_stall;
    bit found;
    rst = 1'b1;
    d0_af = 1'b0;
    d1_af = 1'b0;
    clear_logs();
    repeat (2) @(posedge clk);
    #2;

    // Test 1: reset values while VC0 holds 2 words, then release.
    load(0, 0, 6'h01);
    load(0, 0, 6'h02);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_vc0_rd[%0d]", i), int'(rd_s[i][0]), 0);
      chk($sformatf("rst_vc1_rd[%0d]", i), int'(rd_s[i][1]), 0);
      chk($sformatf("rst_d0_wr[%0d]", i), int'(d_wr_s[i][0]), 0);
      chk($sformatf("rst_d1_wr[%0d]", i), int'(d_wr_s[i][1]), 0);
      chk($sformatf("rst_d0_data[%0d]", i), int'(d_data_s[i][0]), 0);
      chk($sformatf("rst_d1_data[%0d]", i), int'(d_data_s[i][1]), 0);
      chk($sformatf("rst_idle[%0d]", i), int'(idle_s[i]), 1);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rd_hist[k]   = rd_s[0][0];
      wr_hist[k]   = d_wr_s[0][0] | d_wr_s[0][1];
      idle_hist[k] = idle_s[0];
    end
    chk("t1_vc0_rd_cycles", int'(rd_hist), int'(6'b000110));
    chk("t1_d_wr_cycles", int'(wr_hist), int'(6'b011000));
    chk("t1_idle_cycles", int'(idle_hist), int'(6'b100001));
    wait_idle(0);
    chk("t1_d0_pushes", push_cnt[0][0], 2);

    // Test 2: weighted order with default weights.
    clear_logs();
    for (int k = 1; k <= 6; k++) load(0, 0, 6'(k));
    load(0, 1, 6'h11);
    load(0, 1, 6'h12);
    wait_idle(0);
    chk("t2_pop_count", n_pop[0], 8);
    for (int k = 0; k < 8; k++) chk($sformatf("t2_pop_order[%0d]", k), seq[0][k], ord_wrr[k]);
    chk("t2_no_gaps", last_cyc[0] - first_cyc[0], 7);
    chk("t2_d0_pushes", push_cnt[0][0], 6);
    chk("t2_d1_pushes", push_cnt[0][1], 2);

    // Test 3: d1_almost_full for 4 cycles mid-stream.
    clear_logs();
    load(0, 0, 6'h21); load(0, 0, 6'h32); load(0, 0, 6'h23);
    load(0, 0, 6'h34); load(0, 0, 6'h25); load(0, 0, 6'h36);
    repeat (3) @(posedge clk);
    #2 d1_af = 1'b1;
    pops_in_stall = 0;
    pushes_in_stall = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rd_s[0][0] || rd_s[0][1]) pops_in_stall++;
      if (d_wr_s[0][0] || d_wr_s[0][1]) pushes_in_stall++;
    end
    @(posedge clk);
    #2 d1_af = 1'b0;
    chk("t3_pops_in_stall", pops_in_stall, 0);
    chk("t3_pushes_in_stall", pushes_in_stall, 2);
    wait_idle(0);
    chk("t3_pop_count", n_pop[0], 6);
    chk("t3_d0_pushes", push_cnt[0][0], 3);
    chk("t3_d1_pushes", push_cnt[0][1], 3);

    // Test 4: VC1 only.
    clear_logs();
    load(0, 1, 6'h03); load(0, 1, 6'h14); load(0, 1, 6'h05);
    load(0, 1, 6'h16); load(0, 1, 6'h07);
    wait_idle(0);
    chk("t4_pop_count", n_pop[0], 5);
    for (int k = 0; k < 5; k++) chk($sformatf("t4_pop_src[%0d]", k), seq[0][k], 1);
    chk("t4_no_gaps", last_cyc[0] - first_cyc[0], 4);
    chk("t4_d0_pushes", push_cnt[0][0], 3);
    chk("t4_d1_pushes", push_cnt[0][1], 2);

    // Test 5: reset one cycle after the first pop.
    clear_logs();
    for (int k = 1; k <= 4; k++) load(0, 0, 6'(k));
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rd_s[0][0]) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_pop_seen", int'(found), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t5_d0_wr_after_reset", int'(d_wr_s[0][0]), 0);
    chk("t5_d1_wr_after_reset", int'(d_wr_s[0][1]), 0);
    chk("t5_idle_after_reset", int'(idle_s[0]), 1);
    chk("t5_vc0_rd_after_reset", int'(rd_s[0][0]), 0);
    wait_idle(0);
    chk("t5_pop_count", n_pop[0], 4);
    chk("t5_d0_pushes", push_cnt[0][0], 2);

    // Test 6: WEIGHT_VC0=1 instance, both FIFOs loaded -> strict alternation.
    clear_logs();
    for (int k = 1; k <= 4; k++) begin
      load(1, 0, 6'(k));
      load(1, 1, 6'(16 + k));
    end
    wait_idle(1);
    chk("t6_pop_count", n_pop[1], 8);
    for (int k = 0; k < 8; k++) chk($sformatf("t6_pop_order[%0d]", k), seq[1][k], ord_alt[k]);
    chk("t6_d0_pushes", push_cnt[1][0], 4);
    chk("t6_d1_pushes", push_cnt[1][1], 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
